// File: rtl/sticky_capture_bank_pkg.sv
// Shared constants, read FSM state type and select-width helper for the
// sticky capture bank.
package sticky_capture_pkg;

  localparam int EV_LEVEL = 0;
  localparam int EV_EDGE  = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } rd_state_e;

  // Select width never drops below one bit, even for a single channel.
  function automatic int SEL_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sticky_capture_bank_if.sv
// Counter read port of the sticky capture bank.
// rd_req is sampled only while the bank is idle; once rd_valid rises, rd_data
// and rd_valid hold until the cycle rd_ready is seen high, which ends the beat.
interface sticky_capture_bank_if #(
  parameter int SELW  = 2,
  parameter int CNT_W = 8
);
  logic             rd_req;
  logic [SELW-1:0]  rd_sel;
  logic             rd_valid;
  logic             rd_ready;
  logic [CNT_W-1:0] rd_data;

  modport master (output rd_req, rd_sel, rd_ready, input rd_valid, rd_data);
  modport slave  (input rd_req, rd_sel, rd_ready, output rd_valid, rd_data);
endinterface

// File: rtl/sticky_capture_bank_chan.sv
// One capture channel: data register, event detect, sticky flag and a
// saturating event counter that can be reloaded by a read snapshot.
module sticky_capture_chan
  import sticky_capture_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 8,
  parameter int EDGE_MODE = EV_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             clr,
  input  logic             snap_clr,
  output logic [WIDTH-1:0] q,
  output logic             sticky,
  output logic             ev,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Edges are measured against the captured value, so stalls hide glitches.
  assign ev = en & ~flush &
              ((EDGE_MODE == EV_EDGE) ? (|(d & ~q_q)) : (|d));

  always_comb begin
    q_d = q_q;
    if (flush)   q_d = '0;
    else if (en) q_d = d;

    sticky_d = ev | (sticky_q & ~clr);

    cnt_d = cnt_q;
    if (snap_clr)                      cnt_d = {{(CNT_W-1){1'b0}}, ev};
    else if (ev && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q      <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      q_q      <= q_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q      = q_q;
  assign sticky = sticky_q;
  assign cnt    = cnt_q;

endmodule

// File: rtl/sticky_capture_bank.sv
// Multi-channel capture bank with sticky event flags, saturating counters
// and a clear-on-read counter port.
module sticky_capture_bank
  import sticky_capture_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 8,
  parameter int EDGE_MODE = EV_LEVEL
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      flush,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       sticky,
  input  logic [CHANNELS-1:0]       clr,
  sticky_capture_bank_if.slave      rd,
  output logic [CHANNELS-1:0]       ev_o,
  output rd_state_e                 rd_state_o
);

  logic [CHANNELS-1:0] ev;
  logic [CHANNELS-1:0] snap_clr;
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CNT_W-1:0]    sel_cnt;
  logic                accept;

  rd_state_e        state_q;
  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    sticky_capture_chan #(
      .WIDTH    (WIDTH),
      .CNT_W    (CNT_W),
      .EDGE_MODE(EDGE_MODE)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .flush   (flush),
      .d       (d[c*WIDTH +: WIDTH]),
      .clr     (clr[c]),
      .snap_clr(snap_clr[c]),
      .q       (q[c*WIDTH +: WIDTH]),
      .sticky  (sticky[c]),
      .ev      (ev[c]),
      .cnt     (cnt[c])
    );
  end

  assign accept = (state_q == IDLE) && rd.rd_req;

  // Out-of-range selects match no channel: snapshot reads 0, nothing clears.
  always_comb begin
    sel_cnt  = '0;
    snap_clr = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(rd.rd_sel) == c) begin
        sel_cnt     = cnt[c];
        snap_clr[c] = accept;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd.rd_req) begin
            rd_data_q  <= sel_cnt;
            rd_valid_q <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (rd.rd_ready) begin
            rd_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          rd_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;
  assign ev_o        = ev;
  assign rd_state_o  = state_q;

endmodule

// File: tb/tb_sticky_capture_bank.sv
// Directed bench for sticky_capture_bank: a level-mode 4-channel bank with
// 2-bit counters and an edge-mode 3-channel bank share the same stimulus.
module tb_sticky_capture_bank;
  import sticky_capture_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, flush;
  logic [31:0] d;
  logic [3:0]  clr;
  logic        rd_req, rd_ready;
  logic [1:0]  rd_sel;

  logic [31:0] q_l;
  logic [23:0] q_e;
  logic [3:0]  sticky_l, ev_l;
  logic [2:0]  sticky_e, ev_e;
  rd_state_e   st_l, st_e;

  sticky_capture_bank_if #(.SELW(2), .CNT_W(2)) if_l ();
  sticky_capture_bank_if #(.SELW(2), .CNT_W(8)) if_e ();

  assign if_l.rd_req   = rd_req;
  assign if_l.rd_sel   = rd_sel;
  assign if_l.rd_ready = rd_ready;
  assign if_e.rd_req   = rd_req;
  assign if_e.rd_sel   = rd_sel;
  assign if_e.rd_ready = rd_ready;

  sticky_capture_bank #(.WIDTH(8), .CHANNELS(4), .CNT_W(2), .EDGE_MODE(EV_LEVEL)) dut_l (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d), .q(q_l),
    .sticky(sticky_l), .clr(clr), .rd(if_l.slave), .ev_o(ev_l), .rd_state_o(st_l)
  );

  sticky_capture_bank #(.WIDTH(8), .CHANNELS(3), .CNT_W(8), .EDGE_MODE(EV_EDGE)) dut_e (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .d(d[23:0]), .q(q_e),
    .sticky(sticky_e), .clr(clr[2:0]), .rd(if_e.slave), .ev_o(ev_e), .rd_state_o(st_e)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // scoreboard and reference model
  int tests = 0;
  int fails = 0;

  logic [1:0] exp_q_l[$];
  logic [7:0] exp_q_e[$];
  logic [1:0] held_l;
  logic [7:0] held_e;
  logic       prev_valid;

  logic [7:0] mq   [4];
  logic [1:0] mc_l [4];
  logic [7:0] mc_e [3];
  logic [3:0] ms_l;
  logic [2:0] ms_e;
  rd_state_e  m_state;
  logic       m_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < 4; c++) begin
      mq[c]   = '0;
      mc_l[c] = '0;
    end
    for (int c = 0; c < 3; c++) mc_e[c] = '0;
    ms_l       = '0;
    ms_e       = '0;
    m_state    = IDLE;
    m_valid    = 1'b0;
    prev_valid = 1'b0;
    exp_q_l.delete();
    exp_q_e.delete();
  endtask

  // driver: one clock with the currently driven inputs, then check
  task automatic step();
    logic [7:0] nq [4];
    logic       evl, eve, accept;
    logic [7:0] dc;
    accept = (m_state == IDLE) && rd_req;
    if (accept) begin
      exp_q_l.push_back(mc_l[rd_sel]);
      exp_q_e.push_back((rd_sel < 2'd3) ? mc_e[rd_sel] : 8'd0);
    end
    for (int c = 0; c < 4; c++) begin
      dc  = d[c*8 +: 8];
      evl = en & ~flush & (|dc);
      eve = en & ~flush & (|(dc & ~mq[c]));
      if (accept && (int'(rd_sel) == c)) mc_l[c] = {1'b0, evl};
      else if (evl && mc_l[c] != 2'd3)   mc_l[c] = mc_l[c] + 2'd1;
      ms_l[c] = evl | (ms_l[c] & ~clr[c]);
      if (c < 3) begin
        if (accept && (int'(rd_sel) == c)) mc_e[c] = {7'd0, eve};
        else if (eve && mc_e[c] != 8'hFF)  mc_e[c] = mc_e[c] + 8'd1;
        ms_e[c] = eve | (ms_e[c] & ~clr[c]);
      end
      nq[c] = flush ? 8'd0 : (en ? dc : mq[c]);
    end
    if (accept) begin
      m_state = RESP;
      m_valid = 1'b1;
    end else if (m_state == RESP && rd_ready) begin
      m_state = IDLE;
      m_valid = 1'b0;
    end
    @(posedge clk);
    for (int c = 0; c < 4; c++) mq[c] = nq[c];
    #1;
    chk("q_l", q_l, {mq[3], mq[2], mq[1], mq[0]});
    chk("q_e", q_e, {mq[2], mq[1], mq[0]});
    chk("sticky_l", sticky_l, ms_l);
    chk("sticky_e", sticky_e, ms_e);
    chk("rd_valid_l", if_l.rd_valid, m_valid);
    chk("rd_valid_e", if_e.rd_valid, m_valid);
    chk("state_l", 64'(st_l), 64'(m_state));
    if (if_l.rd_valid === 1'b1 && !prev_valid) begin
      if (exp_q_l.size() == 0 || exp_q_e.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_empty observed=response expected=no_response");
      end else begin
        held_l = exp_q_l.pop_front();
        held_e = exp_q_e.pop_front();
        chk("rd_data_l", if_l.rd_data, held_l);
        chk("rd_data_e", if_e.rd_data, held_e);
      end
    end else if (if_l.rd_valid === 1'b1) begin
      chk("rd_hold_l", if_l.rd_data, held_l);
      chk("rd_hold_e", if_e.rd_data, held_e);
    end
    prev_valid = (if_l.rd_valid === 1'b1);
  endtask

  task automatic read_start(input logic [1:0] sel);
    rd_req = 1'b1; rd_sel = sel; rd_ready = 1'b0;
    step();
    rd_req = 1'b0;
  endtask

  task automatic read_finish();
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0; d = '0; clr = '0;
    rd_req = 1'b0; rd_ready = 1'b0; rd_sel = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q_l", q_l, 32'd0);
    chk("rst_sticky_l", sticky_l, 4'd0);
    chk("rst_valid_l", if_l.rd_valid, 1'b0);
    chk("rst_data_l", if_l.rd_data, 2'd0);
    chk("rst_state_l", 64'(st_l), 64'(IDLE));
    @(negedge clk);
    reset = 1'b0;

    // level capture on channel 0
    en = 1'b1; d = 32'h0000_0005;
    step();
    chk("lvl_q0_lat", q_l[7:0], 8'h05);
    step(); step();
    chk("lvl_sticky0", sticky_l, 4'b0001);
    d = '0;
    read_start(2'd0);
    chk("lvl_cnt0", if_l.rd_data, 2'd3);
    chk("edge_cnt0", if_e.rd_data, 8'd1);
    read_finish();

    // edge sequence on channel 1
    d = 32'h0000_0100; step();
    d = 32'h0000_0100; step();
    d = 32'h0000_0300; step();
    d = 32'h0000_0000; step();
    d = 32'h0000_0100; step();
    d = '0;
    read_start(2'd1);
    chk("edge_cnt1", if_e.rd_data, 8'd3);
    chk("lvl_cnt1_sat", if_l.rd_data, 2'd3);
    read_finish();

    // flush during stall, then plain stall
    en = 1'b0; flush = 1'b1; d = 32'h00FF_0000;
    step();
    chk("flush_q2", q_l[23:16], 8'h00);
    chk("flush_sticky2", sticky_l[2], 1'b0);
    flush = 1'b0;
    step();
    chk("stall_q2", q_l[23:16], 8'h00);

    // sticky set/clear race on channel 3
    en = 1'b1; d = 32'h1000_0000; clr = 4'b1000;
    step();
    chk("race_sticky3", sticky_l[3], 1'b1);
    d = '0;
    step();
    chk("clr_sticky3", sticky_l[3], 1'b0);
    clr = '0;

    // saturation, held response, ignored re-request, snapshot-cycle event
    d = 32'h0000_0001;
    repeat (5) step();
    read_start(2'd0);
    d = '0;
    rd_req = 1'b1; rd_sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_data_l", if_l.rd_data, 2'd3);
      chk("hold_valid_l", if_l.rd_valid, 1'b1);
    end
    rd_req = 1'b0;
    read_finish();
    read_start(2'd0);
    chk("snap_ev_cnt0", if_l.rd_data, 2'd1);
    read_finish();

    // out-of-range select on the 3-channel bank
    d = 32'h0100_0000;
    step();
    d = '0;
    read_start(2'd3);
    chk("oor_data_e", if_e.rd_data, 8'd0);
    read_finish();

    // randomised traffic with periodic reads
    for (int i = 0; i < 40; i++) begin
      d     = {$urandom_range(0, 255), $urandom_range(0, 3)} & 32'h0303_03FF;
      en    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      clr   = 4'($urandom_range(0, 15));
      if (i % 8 == 3) begin
        rd_req = 1'b1; rd_sel = 2'($urandom_range(0, 3));
      end else begin
        rd_req = 1'b0;
      end
      rd_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    rd_req = 1'b0; rd_ready = 1'b1; en = 1'b0; flush = 1'b0; clr = '0;
    step();
    rd_ready = 1'b0;

    // asynchronous reset in the middle of a response
    en = 1'b1; d = 32'h0000_0001;
    step();
    read_start(2'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid_l", if_l.rd_valid, 1'b0);
    chk("arst_valid_e", if_e.rd_valid, 1'b0);
    chk("arst_data_l", if_l.rd_data, 2'd0);
    chk("arst_q_l", q_l, 32'd0);
    chk("arst_sticky_l", sticky_l, 4'd0);
    chk("arst_state_l", 64'(st_l), 64'(IDLE));
    m_reset();
    @(negedge clk);
    reset = 1'b0; d = '0;
    read_start(2'd0);
    chk("post_rst_cnt0", if_l.rd_data, 2'd0);
    read_finish();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
